// File: rtl/prbs_pkg.sv
// Shared types and helpers for the parallel PRBS generator/checker.
package prbs_pkg;

   localparam int unsigned POP_MAX_W = 1024;

   typedef enum logic {GEN = 1'b0, CHK = 1'b1} mode_e;
   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_e;

   // Number of set bits; callers zero-extend narrower words to POP_MAX_W.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < int'(POP_MAX_W); i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic [63:0] lim);
      logic [64:0] s;
      s = 65'(a) + 65'(b);
      return (s > 65'(lim)) ? lim : s[63:0];
   endfunction

endpackage

// File: rtl/prbs_step_comb.sv
// One parallel step of a Fibonacci LFSR: DW output bits plus the following state.
module prbs_step_comb #(
   parameter int unsigned     POL_W    = 7,
   parameter logic [POL_W:0]  POL_MASK = 8'hC0,
   parameter int unsigned     DW       = 16
) (
   input  logic [POL_W-1:0] state,
   output logic [DW-1:0]    pn,
   output logic [POL_W-1:0] next_state
);

   // Bits are produced MSB first; each new bit only looks at older (higher) bits.
   function automatic logic [DW-1:0] step(input logic [POL_W-1:0] s);
      logic [DW+POL_W-1:0] e;
      e = {s, {DW{1'b0}}};
      for (int i = int'(DW) - 1; i >= 0; i--) begin
         e[i] = ^(e[i +: POL_W+1] & POL_MASK);
      end
      return e[DW-1:0];
   endfunction

   assign pn         = step(state);
   assign next_state = pn[POL_W-1:0];

endmodule

// File: rtl/prbs_gen_chk.sv
// Parallel PRBS generator / self-synchronising checker with lock tracking and error count.
// Optional build macro PRBS_INV_EN adds an 'invert' port for inverted-pattern links.
module prbs_gen_chk
   import prbs_pkg::*;
#(
   parameter int unsigned    POL_W       = 7,
   parameter logic [POL_W:0] POL_MASK    = 8'hC0,
   parameter int unsigned    DW          = 16,
   parameter int unsigned    ERR_CNT_W   = 16,
   parameter int unsigned    LOCK_THRESH = 4,
   parameter int unsigned    LOSS_THRESH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef PRBS_INV_EN
   input  logic                 invert,
`endif
   input  logic                 mode,
   input  logic                 seed_load,
   input  logic [POL_W-1:0]     seed,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   input  logic                 clr_err,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic                 locked,
   output logic                 err_flag,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned THR_MAX = (LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH;
   localparam int unsigned CNT_W   = $clog2(THR_MAX + 1);
   localparam logic [63:0] ERR_MAX = (ERR_CNT_W >= 64) ? {64{1'b1}}
                                     : (64'(1) << ERR_CNT_W) - 64'd1;

   localparam logic [0:0] S_HUNT   = HUNT;
   localparam logic [0:0] S_LOCKED = LOCKED;

   if (POL_MASK[0] != 1'b0) begin : g_bad_mask
      $error("prbs_gen_chk: POL_MASK bit 0 must be 0");
   end
   if (DW < POL_W) begin : g_bad_dw
      $error("prbs_gen_chk: DW must be >= POL_W");
   end
   if (DW > POP_MAX_W) begin : g_dw_too_wide
      $error("prbs_gen_chk: DW exceeds popcount width");
   end

   logic              inv;
`ifdef PRBS_INV_EN
   assign inv = invert;
`else
   assign inv = 1'b0;
`endif

   logic [POL_W-1:0]     state, state_nxt;
   logic [0:0]           fsm, fsm_nxt;
   logic                 mode_q;
   logic [CNT_W-1:0]     clean_cnt, clean_nxt;
   logic [CNT_W-1:0]     bad_cnt, bad_nxt;
   logic                 locked_nxt, out_valid_nxt, err_flag_nxt;
   logic [DW-1:0]        out_data_nxt;
   logic [ERR_CNT_W-1:0] err_count_nxt;

   logic [DW-1:0]        pn, exp_word, sync_word;
   logic [POL_W-1:0]     next_state;
   int unsigned          nerr;

   prbs_step_comb #(
      .POL_W    (POL_W),
      .POL_MASK (POL_MASK),
      .DW       (DW)
   ) u_step (
      .state      (state),
      .pn         (pn),
      .next_state (next_state)
   );

   assign exp_word  = inv ? ~pn : pn;
   assign sync_word = inv ? ~in_data : in_data;
   assign nerr      = popcount(POP_MAX_W'(exp_word ^ in_data));

   // Next-state and output decode.
   always_comb begin
      fsm_nxt       = fsm;
      locked_nxt    = locked;
      clean_nxt     = clean_cnt;
      bad_nxt       = bad_cnt;
      state_nxt     = state;
      out_data_nxt  = out_data;
      out_valid_nxt = 1'b0;
      err_flag_nxt  = 1'b0;
      err_count_nxt = err_count;

      if (mode == GEN) begin
         if (seed_load) begin
            state_nxt = (seed == '0) ? '1 : seed;
         end else if (in_valid) begin
            out_data_nxt  = exp_word;
            out_valid_nxt = 1'b1;
            state_nxt     = next_state;
         end
      end else if (in_valid) begin
         out_data_nxt  = exp_word;
         out_valid_nxt = 1'b1;
         if (fsm == S_HUNT) begin
            state_nxt = sync_word[POL_W-1:0];
            if (nerr == 0) begin
               if (clean_cnt == CNT_W'(LOCK_THRESH - 1)) begin
                  fsm_nxt    = S_LOCKED;
                  locked_nxt = 1'b1;
                  clean_nxt  = '0;
                  bad_nxt    = '0;
               end else begin
                  clean_nxt = clean_cnt + CNT_W'(1);
               end
            end else begin
               clean_nxt = '0;
            end
         end else begin
            state_nxt     = next_state;
            err_flag_nxt  = (nerr != 0);
            err_count_nxt = ERR_CNT_W'(sat_add(64'(err_count), 64'(nerr), ERR_MAX));
            if (nerr != 0) begin
               if (bad_cnt == CNT_W'(LOSS_THRESH - 1)) begin
                  fsm_nxt    = S_HUNT;
                  locked_nxt = 1'b0;
                  clean_nxt  = '0;
                  bad_nxt    = '0;
               end else begin
                  bad_nxt = bad_cnt + CNT_W'(1);
               end
            end else begin
               bad_nxt = '0;
            end
         end
      end

      // A mode switch restarts acquisition; the LFSR state itself is kept.
      if (mode != mode_q) begin
         fsm_nxt       = S_HUNT;
         locked_nxt    = 1'b0;
         clean_nxt     = '0;
         bad_nxt       = '0;
         err_flag_nxt  = 1'b0;
         err_count_nxt = err_count;
      end

      if (clr_err) begin
         err_count_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= '1;
         fsm       <= S_HUNT;
         mode_q    <= GEN;
         clean_cnt <= '0;
         bad_cnt   <= '0;
         locked    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err_flag  <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         fsm       <= fsm_nxt;
         mode_q    <= mode;
         clean_cnt <= clean_nxt;
         bad_cnt   <= bad_nxt;
         locked    <= locked_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         err_flag  <= err_flag_nxt;
         err_count <= err_count_nxt;
      end
   end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench: generator, checker fed by a second generator, and a narrow-counter copy.
module tb_prbs_gen_chk;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        rst_n = 1'b0;
   logic        seed_load = 1'b0;
   logic [6:0]  seed = 7'h00;
   logic        clr_err = 1'b0;
   logic        invert = 1'b0;

   logic        dut_mode = 1'b0;
   logic        tb_valid = 1'b0;
   logic [15:0] tb_data = 16'h0000;
   logic        feed = 1'b0;
   logic [15:0] corrupt = 16'h0000;

   logic        gen_mode = 1'b0;
   logic        gen_valid = 1'b0;
   logic [15:0] gen_in_data = 16'h0000;
   logic        gen_clr = 1'b0;

   logic        gen_out_valid, gen_locked, gen_err_flag;
   logic [15:0] gen_out_data, gen_err_count;
   logic        out_valid, locked, err_flag;
   logic [15:0] out_data, err_count;
   logic        sat_out_valid, sat_locked, sat_err_flag;
   logic [15:0] sat_out_data;
   logic [3:0]  sat_err_count;

   logic        dut_in_valid;
   logic [15:0] dut_in_data;
   assign dut_in_valid = feed ? gen_out_valid : tb_valid;
   assign dut_in_data  = feed ? (gen_out_data ^ corrupt) : tb_data;

   prbs_gen_chk #(.POL_W(7), .POL_MASK(8'hC0), .DW(16), .ERR_CNT_W(16),
                  .LOCK_THRESH(4), .LOSS_THRESH(4)) u_gen (
      .clk(clk), .rst_n(rst_n),
`ifdef PRBS_INV_EN
      .invert(invert),
`endif
      .mode(gen_mode), .seed_load(seed_load), .seed(seed),
      .in_valid(gen_valid), .in_data(gen_in_data), .clr_err(gen_clr),
      .out_valid(gen_out_valid), .out_data(gen_out_data), .locked(gen_locked),
      .err_flag(gen_err_flag), .err_count(gen_err_count)
   );

   prbs_gen_chk #(.POL_W(7), .POL_MASK(8'hC0), .DW(16), .ERR_CNT_W(16),
                  .LOCK_THRESH(4), .LOSS_THRESH(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
`ifdef PRBS_INV_EN
      .invert(invert),
`endif
      .mode(dut_mode), .seed_load(seed_load), .seed(seed),
      .in_valid(dut_in_valid), .in_data(dut_in_data), .clr_err(clr_err),
      .out_valid(out_valid), .out_data(out_data), .locked(locked),
      .err_flag(err_flag), .err_count(err_count)
   );

   prbs_gen_chk #(.POL_W(7), .POL_MASK(8'hC0), .DW(16), .ERR_CNT_W(4),
                  .LOCK_THRESH(4), .LOSS_THRESH(4)) u_sat (
      .clk(clk), .rst_n(rst_n),
`ifdef PRBS_INV_EN
      .invert(invert),
`endif
      .mode(dut_mode), .seed_load(seed_load), .seed(seed),
      .in_valid(dut_in_valid), .in_data(dut_in_data), .clr_err(clr_err),
      .out_valid(sat_out_valid), .out_data(sat_out_data), .locked(sat_locked),
      .err_flag(sat_err_flag), .err_count(sat_err_count)
   );

   // Bit-serial reference for x^7+x^6+1, oldest bit in r[6].
   function automatic void ref_word(input logic [6:0] st, output logic [15:0] w,
                                    output logic [6:0] ns);
      logic [6:0] r;
      logic       b;
      r = st;
      w = 16'h0000;
      for (int i = 15; i >= 0; i--) begin
         b    = r[6] ^ r[5];
         w[i] = b;
         r    = {r[5:0], b};
      end
      ns = w[6:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_out: got valid=%0b data=%h want 0/0000", out_valid, out_data);
      end
      checks++;
      if (locked !== 1'b0 || err_flag !== 1'b0 || err_count !== 16'h0000) begin
         errors++;
         $display("FAIL reset_status: got locked=%0b flag=%0b cnt=%0d want 0/0/0",
                  locked, err_flag, err_count);
      end
      checks++;
      if (gen_out_valid !== 1'b0 || gen_locked !== 1'b0 || gen_err_flag !== 1'b0 ||
          gen_err_count !== 16'h0000 || sat_out_valid !== 1'b0 || sat_out_data !== 16'h0000 ||
          sat_locked !== 1'b0 || sat_err_flag !== 1'b0 || sat_err_count !== 4'h0) begin
         errors++;
         $display("FAIL reset_other: gen v=%0b l=%0b f=%0b c=%0d sat v=%0b d=%h l=%0b f=%0b c=%0d want all 0",
                  gen_out_valid, gen_locked, gen_err_flag, gen_err_count, sat_out_valid,
                  sat_out_data, sat_locked, sat_err_flag, sat_err_count);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_gen_seed();
      logic [6:0]  ms, ns;
      logic [15:0] w, first;
      bit          early_repeat;
      early_repeat = 1'b0;
      first = 16'h0000;
      dut_mode = 1'b0;
      feed = 1'b0;
      seed = 7'h7F;
      seed_load = 1'b1;
      tb_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL seed_load_no_beat: got valid=%0b want 0", out_valid);
      end
      seed_load = 1'b0;
      ms = 7'h7F;
      for (int k = 0; k < 128; k++) begin
         ref_word(ms, w, ns);
         tick();
         if (k == 0) begin
            first = out_data;
            checks++;
            if (out_data !== 16'h020C || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL gen_first_word: got %h v=%0b want 020C v=1", out_data, out_valid);
            end
         end
         if (k == 1) begin
            checks++;
            if (out_data !== 16'h28F2) begin
               errors++;
               $display("FAIL gen_second_word: got %h want 28F2", out_data);
            end
         end
         checks++;
         if (out_data !== w) begin
            errors++;
            $display("FAIL gen_seq[%0d]: got %h want %h", k, out_data, w);
         end
         if (k > 0 && k < 127 && out_data === first) early_repeat = 1'b1;
         if (k == 127) begin
            checks++;
            if (out_data !== first || early_repeat) begin
               errors++;
               $display("FAIL gen_period: got beat127=%h early=%0b want %h early=0",
                        out_data, early_repeat, first);
            end
         end
         ms = ns;
      end
      tb_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL gen_idle_valid: got %0b want 0", out_valid);
      end
      tick();
      tb_valid = 1'b1;
      ref_word(ms, w, ns);
      tick();
      checks++;
      if (out_data !== w || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL gen_hold_state: got %h v=%0b want %h v=1", out_data, out_valid, w);
      end
      tb_valid = 1'b0;
   endtask

   task automatic test_zero_seed();
      seed = 7'h00;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      tb_valid = 1'b1;
      tick();
      checks++;
      if (out_data !== 16'h020C) begin
         errors++;
         $display("FAIL zero_seed_w0: got %h want 020C", out_data);
      end
      tick();
      checks++;
      if (out_data !== 16'h28F2) begin
         errors++;
         $display("FAIL zero_seed_w1: got %h want 28F2", out_data);
      end
      tb_valid = 1'b0;
   endtask

   task automatic test_lock();
      bit bad;
      rst_n = 1'b0;
      tick();
      tick();
      dut_mode = 1'b1;
      feed = 1'b1;
      corrupt = 16'h0000;
      gen_valid = 1'b1;
      rst_n = 1'b1;
      tick();
      for (int b = 1; b <= 4; b++) begin
         tick();
         if (b == 1) begin
            checks++;
            if (out_data !== 16'h020C || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL chk_expected_w0: got %h v=%0b want 020C v=1", out_data, out_valid);
            end
         end
         checks++;
         if (locked !== (b == 4)) begin
            errors++;
            $display("FAIL lock_beat%0d: got locked=%0b want %0b", b, locked, (b == 4));
         end
      end
      bad = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (err_flag !== 1'b0 || locked !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad || err_count !== 16'd0 || sat_err_count !== 4'd0) begin
         errors++;
         $display("FAIL clean_run: got bad=%0b cnt=%0d sat=%0d want 0/0/0",
                  bad, err_count, sat_err_count);
      end
   endtask

   task automatic test_single_err();
      corrupt = 16'h0007;
      tick();
      corrupt = 16'h0000;
      checks++;
      if (err_flag !== 1'b1 || err_count !== 16'd3 || locked !== 1'b1) begin
         errors++;
         $display("FAIL single_err: got flag=%0b cnt=%0d locked=%0b want 1/3/1",
                  err_flag, err_count, locked);
      end
      tick();
      checks++;
      if (err_flag !== 1'b0 || err_count !== 16'd3 || sat_err_count !== 4'd3) begin
         errors++;
         $display("FAIL single_err_after: got flag=%0b cnt=%0d sat=%0d want 0/3/3",
                  err_flag, err_count, sat_err_count);
      end
   endtask

   task automatic test_loss_relock();
      logic [15:0] hunt_pat [7];
      hunt_pat = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      for (int b = 1; b <= 4; b++) begin
         corrupt = 16'h0100;
         tick();
         checks++;
         if (locked !== (b < 4)) begin
            errors++;
            $display("FAIL loss_beat%0d: got locked=%0b want %0b", b, locked, (b < 4));
         end
      end
      corrupt = 16'h0000;
      checks++;
      if (err_count !== 16'd7) begin
         errors++;
         $display("FAIL loss_count: got %0d want 7", err_count);
      end
      for (int b = 0; b < 7; b++) begin
         corrupt = hunt_pat[b];
         tick();
         checks++;
         if (locked !== (b == 6)) begin
            errors++;
            $display("FAIL relock_beat%0d: got locked=%0b want %0b", b, locked, (b == 6));
         end
      end
      corrupt = 16'h0000;
      checks++;
      if (err_count !== 16'd7 || err_flag !== 1'b0) begin
         errors++;
         $display("FAIL hunt_no_count: got cnt=%0d flag=%0b want 7/0", err_count, err_flag);
      end
   endtask

   task automatic test_clr_err();
      corrupt = 16'h0003;
      clr_err = 1'b1;
      tick();
      corrupt = 16'h0000;
      clr_err = 1'b0;
      checks++;
      if (err_count !== 16'd0 || err_flag !== 1'b1 || sat_err_count !== 4'd0) begin
         errors++;
         $display("FAIL clr_err_priority: got cnt=%0d flag=%0b sat=%0d want 0/1/0",
                  err_count, err_flag, sat_err_count);
      end
      tick();
   endtask

   task automatic test_saturation();
      for (int b = 1; b <= 4; b++) begin
         corrupt = 16'h001F;
         tick();
         checks++;
         if (err_count !== 16'(5 * b) || sat_err_count !== ((b >= 3) ? 4'd15 : 4'(5 * b))) begin
            errors++;
            $display("FAIL saturate_beat%0d: got cnt=%0d sat=%0d want %0d/%0d", b, err_count,
                     sat_err_count, 5 * b, (b >= 3) ? 15 : 5 * b);
         end
         corrupt = 16'h0000;
         tick();
      end
      checks++;
      if (locked !== 1'b1 || sat_err_count !== 4'd15) begin
         errors++;
         $display("FAIL saturate_hold: got locked=%0b sat=%0d want 1/15", locked, sat_err_count);
      end
   endtask

   task automatic test_mode_change();
      dut_mode = 1'b0;
      tick();
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL mode_change_unlock: got locked=%0b want 0", locked);
      end
   endtask

   task automatic test_reset_mid();
      feed = 1'b0;
      tb_valid = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || gen_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got v=%0b d=%h genv=%0b want 0/0000/0",
                  out_valid, out_data, gen_out_valid);
      end
      gen_valid = 1'b0;
      tb_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_invert();
`ifdef PRBS_INV_EN
      do_reset();
      dut_mode = 1'b0;
      feed = 1'b0;
      invert = 1'b1;
      tb_valid = 1'b1;
      tick();
      checks++;
      if (out_data !== 16'hFDF3) begin
         errors++;
         $display("FAIL invert_first_word: got %h want FDF3", out_data);
      end
      tb_valid = 1'b0;
      invert = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_gen_seed();
      test_zero_seed();
      test_lock();
      test_single_err();
      test_loss_relock();
      test_clr_err();
      test_saturation();
      test_mode_change();
      test_reset_mid();
      test_invert();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Clocked parallel PRBS engine that produces or checks DW bits of a Fibonacci LFSR sequence per beat.
- Polynomial (tap mask), state width and data width are parameters.
- Generate mode: registered pattern source for link/BIST datapaths.
- Check mode: self-synchronises to incoming data, tracks lock, and accumulates a bit-error count.

Parameters:
POL_W, 7, LFSR state width / polynomial degree.
POL_MASK, 8'hC0, tap mask of width POL_W+1. Bit k set means tap at offset k. Bit 0 must be 0; elaboration error otherwise. Default = x^7+x^6+1.
DW, 16, bits per beat. Must be >= POL_W; elaboration error otherwise.
ERR_CNT_W, 16, error counter width.
LOCK_THRESH, 4, consecutive clean beats needed to declare lock.
LOSS_THRESH, 4, consecutive errored beats needed to declare loss of lock.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mode  in  1  0 = generate, 1 = check; sampled every cycle
seed_load  in  1  load seed into state register (generate mode)
seed  in  POL_W  seed value
in_valid  in  1  beat strobe; advance/compare enable
in_data  in  DW  received data (check mode)
clr_err  in  1  clear err_count
out_valid  out  1  registered copy of in_valid
out_data  out  DW  generated word (gen) / expected word (check)
locked  out  1  checker lock status
err_flag  out  1  current beat had >=1 bit error while locked
err_count  out  ERR_CNT_W  saturating accumulated bit errors

Behaviour:
- Reset (rst_n low at clk edge): state = all ones; out_valid = 0; out_data = 0; locked = 0; err_flag = 0; err_count = 0; FSM = HUNT.
- Step function, combinational, per beat:
  - Build e[DW+POL_W-1:0] = {state, pn}.
  - For each i: pn[i] = XOR-reduce(e[i +: POL_W+1] & POL_MASK).
  - next_state = pn[POL_W-1:0].
- Generate mode:
  - seed_load has priority over in_valid.
  - seed_load: state <= seed, or all ones if seed == 0 (lock-up avoidance). No output beat.
  - in_valid (without seed_load): out_data <= pn, state <= next_state, out_valid <= 1.
  - Latency is 1 cycle. When in_valid is low, state holds and out_valid = 0.
- Check mode FSM:
  - Two states, HUNT and LOCKED. seed_load is ignored. Errors are counted only on in_valid beats.
  - expected = pn computed from state.
  - nerr = popcount(expected ^ in_data), computed to full width.
  - HUNT: each beat, state <= in_data[POL_W-1:0] (self-sync). A clean beat (nerr == 0) increments the clean counter; an errored beat clears it. When the clean counter reaches LOCK_THRESH, go to LOCKED and set locked = 1 on the next cycle. err_count does not change in HUNT.
  - LOCKED: state <= next_state (free-running prediction, independent of in_data).
    - err_count <= min(err_count + nerr, 2^ERR_CNT_W - 1).
    - err_flag <= (nerr != 0).
    - Consecutive errored beats reaching LOSS_THRESH: go to HUNT, locked <= 0, clean counter cleared.
  - out_data = expected, registered, with out_valid.
- clr_err has priority over accumulation: err_count <= 0 in that cycle, even if an errored beat arrives.
- A mode change forces FSM = HUNT and clears locked and both threshold counters; state is unchanged.
- Reset mid-stream aborts immediately; no partial beat is output.

Optional Feature:
PRBS_INV_EN.
- Defined: adds input port invert (1 bit). When invert = 1, out_data is bitwise inverted, and the check compare uses ~expected. In check mode, the self-sync load uses ~in_data. The state recurrence itself is unaffected.
- Undefined: no invert port; behaviour identical to invert = 0.

Decomposition:
Package prbs_pkg holds:
- mode_e (GEN, CHK)
- lock_state_e (HUNT, LOCKED)
- function popcount
- saturating-add helper

Sub-module prbs_step_comb (POL_W, POL_MASK, DW), purely combinational: state -> pn, next_state. It is instantiated once; its only consumer is prbs_gen_chk.

Test Plan:
- Reset, gen mode, seed_load with 7'h7F, then in_valid -> first out_data = 16'h020C, next state = 7'h0C. The word sequence repeats after exactly 127 beats.
- seed_load with seed 7'h00 -> state = 7'h7F; output identical to the previous case.
- Check mode, stream from a second gen instance -> locked rises on the 5th cycle after the 4th clean beat. err_count stays 0 over 1000 beats.
- While locked, flip 3 bits in one beat -> err_flag = 1 for one cycle, err_count += 3, locked stays 1.
- While locked, corrupt 4 consecutive beats -> locked = 0, then relock after 4 clean beats. clr_err asserted with an errored beat -> err_count = 0.
- ERR_CNT_W = 4, inject 20 errors -> err_count saturates at 15. With PRBS_INV_EN and invert = 1, first word = 16'hFDF3.
